cook_ctrl: RTL

Top-level sequencer for the microwave's countdown timer (sec_ones/sec_tens/mins chain).
- Accepts keypad digits and shifts them into the timer through its load path.
- Handles start/stop/clear and door interlock; generates the 1 Hz decrement enable from the system clock.
- Drives magnetron enable and the end-of-cook buzzer.
- Sits between the keypad/door front end and the timer instance.

---
 rtl/cook_if.sv | 29 ++
 rtl/cook_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cook_if.sv
// Front-end / timer signal bundle for the microwave cook sequencer.
// slave = sequencer side, master = keypad/door/timer environment side.
interface cook_if;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       start;
   logic       stop;
   logic       clear;
   logic       door_closed;
   logic       timer_zero;
   logic [3:0] timer_data;
   logic       timer_loadn;
   logic       timer_clrn;
   logic       timer_en;
   logic       mag_on;
   logic       buzzer;
   logic [2:0] state;
   logic [1:0] digit_cnt;

   modport slave (
      input  key_valid, key_digit, start, stop, clear, door_closed, timer_zero,
      output timer_data, timer_loadn, timer_clrn, timer_en, mag_on, buzzer, state, digit_cnt
   );

   modport master (
      output key_valid, key_digit, start, stop, clear, door_closed, timer_zero,
      input  timer_data, timer_loadn, timer_clrn, timer_en, mag_on, buzzer, state, digit_cnt
   );
endinterface

// File: rtl/cook_ctrl.sv
// Microwave cook sequencer: keypad digit loading, start/stop/clear/door handling,
// 1 Hz decrement tick generation, magnetron enable and end-of-cook buzzer.
module cook_ctrl #(
   parameter int unsigned TICK_DIV    = 100,
   parameter int unsigned DONE_CYCLES = 300
) (
   input  logic   clk,
   input  logic   clrn,
   cook_if.slave  bus
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DONE_MAX  = DW'(DONE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [DW-1:0] done_q, done_d;
   logic [3:0]    shadow_q, shadow_d;
   logic [1:0]    dcnt_q, dcnt_d;
   logic [3:0]    data_q, data_d;
   logic          loadn_q, loadn_d;
   logic          clrn_q, clrn_d;
   logic          en_q, en_d;
   logic          mag_q, mag_d;
   logic          buz_q, buz_d;

   logic          in_entry;
   logic          key_ok;
   logic          dig_accept;
   logic          clr_pulse;

   // A digit is taken only if it is BCD, there is room, and shifting keeps sec_tens <= 5.
   assign in_entry   = (state_q == S_IDLE) || (state_q == S_SET);
   assign key_ok     = bus.key_valid && (bus.key_digit <= 4'd9) &&
                       (dcnt_q != 2'd3) && (shadow_q <= 4'd5);
   assign dig_accept = in_entry && key_ok && !bus.clear && !bus.stop && !bus.start;
   assign clr_pulse  = bus.clear ||
                       (bus.stop && ((state_q == S_SET) || (state_q == S_PAUSE)));

   // State register and all registered outputs / datapath.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         done_q   <= '0;
         shadow_q <= '0;
         dcnt_q   <= '0;
         data_q   <= '0;
         loadn_q  <= 1'b1;
         clrn_q   <= 1'b1;
         en_q     <= 1'b0;
         mag_q    <= 1'b0;
         buz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
         shadow_q <= shadow_d;
         dcnt_q   <= dcnt_d;
         data_q   <= data_d;
         loadn_q  <= loadn_d;
         clrn_q   <= clrn_d;
         en_q     <= en_d;
         mag_q    <= mag_d;
         buz_q    <= buz_d;
      end
   end

   // Next-state logic; clear beats stop beats door beats start beats digits.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.clear)       state_d = S_IDLE;
            else if (dig_accept) state_d = S_SET;
         end
         S_SET: begin
            if (bus.clear || bus.stop) begin
               state_d = S_IDLE;
            end else if (bus.start) begin
               if (bus.door_closed && !bus.timer_zero) state_d = S_COOK;
            end
         end
         S_COOK: begin
            if (bus.clear)                        state_d = S_IDLE;
            else if (bus.stop || !bus.door_closed) state_d = S_PAUSE;
            else if (bus.timer_zero)              state_d = S_DONE;
         end
         S_PAUSE: begin
            if (bus.clear || bus.stop)                state_d = S_IDLE;
            else if (bus.start && bus.door_closed)    state_d = S_COOK;
         end
         S_DONE: begin
            if (bus.clear || bus.stop || !bus.door_closed) state_d = S_IDLE;
            else if (done_q == DONE_MAX)                   state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      presc_d  = presc_q;
      done_d   = '0;
      shadow_d = shadow_q;
      dcnt_d   = dcnt_q;
      data_d   = data_q;
      loadn_d  = 1'b1;
      clrn_d   = 1'b1;
      en_d     = 1'b0;
      mag_d    = (state_d == S_COOK);
      buz_d    = (state_d == S_DONE);

      if (clr_pulse) clrn_d = 1'b0;

      if (dig_accept) begin
         loadn_d  = 1'b0;
         data_d   = bus.key_digit;
         shadow_d = bus.key_digit;
         dcnt_d   = dcnt_q + 2'd1;
      end else if ((state_d == S_IDLE) && ((state_q != S_IDLE) || bus.clear)) begin
         shadow_d = '0;
         dcnt_d   = '0;
      end

      // Fresh start zeroes the prescaler; resume from PAUSE keeps the held count.
      if ((state_q == S_SET) && (state_d == S_COOK)) begin
         presc_d = '0;
      end else if ((state_q == S_COOK) && (state_d == S_COOK)) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            en_d    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      if ((state_q == S_DONE) && (state_d == S_DONE)) done_d = done_q + DW'(1);
   end

   assign bus.state       = state_q;
   assign bus.digit_cnt   = dcnt_q;
   assign bus.timer_data  = data_q;
   assign bus.timer_loadn = loadn_q;
   assign bus.timer_clrn  = clrn_q;
   assign bus.timer_en    = en_q;
   assign bus.mag_on      = mag_q;
   assign bus.buzzer      = buz_q;

endmodule
